uart_io: RTL
============

# uart_io

Byte-level UART bridge on the processor's IO side of the memory/IO management unit. Serialises bytes the MMU writes to the UART data address onto `uart_txd`. Deserialises `uart_rxd` into a receive FIFO that feeds the MMU's UART read path, and its interrupt-pending input, through the `io_in_*` handshake. Reports sticky line errors on `io_err`.

## Interface
- `CLK_HZ`, 100000000, system clock frequency in Hz
- `BAUD`, 115200, line rate; `CPB = CLK_HZ/BAUD` clocks per bit, integer division, must be ≥ 8
- `RX_DEPTH`, 16, receive FIFO entries, power of two
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset
- `uart_rxd`  in  1  serial input, asynchronous, idles high
- `uart_txd`  out  1  serial output
- `io_out_data`  in  8  byte to transmit
- `io_out_vld`  in  1  TX byte valid
- `io_out_rdy`  out  1  transmitter can accept a byte
- `io_in_data`  out  8  head of the RX FIFO (first-word fall-through)
- `io_in_vld`  out  1  RX FIFO non-empty
- `io_in_rdy`  in  1  consumer pops the head
- `io_err`  out  5  sticky flags `{any, parity, frame, overrun, lost}`
- `err_clr`  in  1  one-cycle pulse that clears all of `io_err`

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- TX FSM states: `TX_IDLE`, `TX_START`, `TX_DATA`, `TX_PAR`, `TX_STOP`.
  - `io_out_rdy` is 1 only in `TX_IDLE`.
  - A transfer occurs on `io_out_vld & io_out_rdy`: the byte is latched and the FSM enters `TX_START`.
  - Each state holds for `CPB` clocks; a 3-bit bit index counts 0..7 in `TX_DATA`.
  - From `TX_STOP` the FSM returns to `TX_IDLE`.
- RX path:
  - `uart_rxd` passes through a 2-flop synchroniser.
  - RX FSM states: `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_PAR`, `RX_STOP`.
  - A falling edge in `RX_IDLE` enters `RX_START`. At `CPB/2` the line is re-sampled: if it is 1, set `lost` and return to idle (glitch); if it is 0, proceed.
  - From then on the line is sampled every `CPB` clocks, at mid-bit.
  - At the stop sample:
    - stop = 0: set `frame`, drop the byte.
    - parity mismatch: set `parity`, drop the byte.
    - FIFO full: set `overrun`, drop the byte.
    - otherwise push the byte.
  - After the stop sample, return to `RX_IDLE`.
- FIFO pop occurs on `io_in_vld & io_in_rdy`.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, the push is accepted, and `overrun` is not set.
- `io_err[4]` is the OR of bits 3..0, registered.
- Error set and `err_clr` in the same cycle: set wins.
- Pointers are `$clog2(RX_DEPTH)+1` bits wide and wrap naturally.
  - Full when the MSBs differ and the rest are equal.
  - Empty when the pointers are equal.

## Timing
- Reset values: `uart_txd=1`, `io_out_rdy=0`, `io_in_vld=0`, `io_in_data=0`, `io_err=0`; both FSMs idle, FIFO empty.
- `io_out_rdy` rises the cycle after reset deasserts.
- TX latency: the start bit appears on `uart_txd` the cycle after the accept. The frame lasts `10*CPB` clocks (`11*CPB` with parity).
- `io_out_rdy` falls the cycle after the accept and rises the cycle after the last stop-bit clock.
- The producer holds `io_out_vld` and data stable until it sees rdy, then may drop `vld` one cycle later. Since `rdy` is already low by then, no duplicate send occurs.
- RX: a pushed byte is visible on `io_in_vld`/`io_in_data` in the cycle after the stop sample. Synchroniser delay is 2 clocks.
- `io_in_data` updates to the next entry in the cycle after a pop.
- `rst` mid-frame aborts both FSMs immediately, drives `uart_txd` high and empties the FIFO.

## Configuration
- `UART_PARITY_EN` defined: even parity. TX inserts the XOR of the data bits in `TX_PAR`; RX checks it in `RX_PAR`. Frame is 11 bits.
- Undefined: 8N1 frames; the `TX_PAR`/`RX_PAR` states are never entered; `io_err[3]` is tied to 0.

## Structure
- Package `uart_pkg`:
  - TX and RX state enums.
  - `io_err` bit-index localparams (`ERR_ANY=4`, `ERR_PARITY=3`, `ERR_FRAME=2`, `ERR_OVERRUN=1`, `ERR_LOST=0`).
  - Start/stop bit level constants.
- One sub-module, `uart_rx_fifo`: synchronous FWFT FIFO, parameter `DEPTH`, with push/pop/full/empty.
- TX FSM, RX FSM, synchroniser and error flags stay in `uart_io`.

## Test plan
Use `CLK_HZ=8000000`, `BAUD=1000000` (`CPB=8`) for all scenarios.
- Reset release; drive `io_out_data=0x55`, `vld=1` → accept the cycle after `rdy` rises. `uart_txd` shows `0,1,0,1,0,1,0,1,0,1`, 8 clocks per bit. `rdy` is back at 1 after 80 clocks.
- Serial byte `0xA3` on `rxd`, `io_in_rdy=0` → `io_in_vld=1`, `io_in_data=0xA3`, `io_err=0`. Pulse `rdy` → `vld=0` the next cycle.
- 17 bytes `0x00..0x10` with no pops → FIFO holds `0x00..0x0F`, `io_err=5'b10010` (any, overrun). `err_clr` → `io_err=0`.
- Frame with stop bit 0 → no push, `io_err=5'b10100`. A 2-clock low glitch on idle `rxd` → `io_err` additionally shows `lost` (`5'b10101`).
- With `UART_PARITY_EN`: byte `0x07` with parity bit 0 → dropped, `io_err=5'b11000`. The same byte with parity 1 → pushed.
- Assert `rst` at bit 4 of a TX frame and during RX `DATA` → `uart_txd=1` the next cycle, FIFO empty, subsequent frames work correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: TX/RX state encodings, io_err bit positions, line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_e;

    localparam int ERR_ANY     = 4;
    localparam int ERR_PARITY  = 3;
    localparam int ERR_FRAME   = 2;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_LOST    = 0;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO for received UART data.
// Latency: a push is visible on rdat_o/empty_o the cycle after it is written.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] wdat_i,
    input  logic       pop_i,
    output logic [7:0] rdat_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

    // Head is forced to zero while empty so the output has a defined reset value.
    assign rdat_o = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdat_i;
        end
    end

endmodule

// File: rtl/uart_io.sv
// UART byte bridge (8N1, or 8E1 when UART_PARITY_EN is defined) with RX FIFO and sticky errors.
// Latency: TX start bit one cycle after accept; RX byte visible one cycle after stop sample.
// Backpressure: io_out_rdy only in TX idle; RX bytes arriving to a full, unpopped FIFO are dropped.
module uart_io
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int BAUD     = 115200,
    parameter int RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic       uart_txd,
    input  logic [7:0] io_out_data,
    input  logic       io_out_vld,
    output logic       io_out_rdy,
    output logic [7:0] io_in_data,
    output logic       io_in_vld,
    input  logic       io_in_rdy,
    output logic [4:0] io_err,
    input  logic       err_clr
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_txd_q, tx_txd_d;
    logic          tx_rdy_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (io_out_vld && tx_rdy_q) begin
                    tx_byte_d  = io_out_data;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CPB_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CPB_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PAR;
`else
                        tx_state_d = TX_STOP;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_PAR: begin
                if (tx_cnt_q == CPB_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CPB_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level is registered from the next state so the start bit leaves the cycle after accept.
        case (tx_state_d)
            TX_START: tx_txd_d = START_BIT;
            TX_DATA:  tx_txd_d = tx_byte_d[tx_bit_d];
            TX_PAR:   tx_txd_d = even_par(tx_byte_d);
            default:  tx_txd_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_txd_q   <= STOP_BIT;
            tx_rdy_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_txd_q   <= tx_txd_d;
            tx_rdy_q   <= (tx_state_d == TX_IDLE);
        end
    end

    assign uart_txd   = tx_txd_q;
    assign io_out_rdy = tx_rdy_q;

    logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
`ifdef UART_PARITY_EN
    logic          rx_par_bad_q, rx_par_bad_d;
`endif
    logic          rx_push, rx_pop, fifo_full, fifo_empty;
    logic          set_lost, set_frame, set_parity, set_overrun;

    assign io_in_vld = !fifo_empty;
    assign rx_pop    = io_in_vld && io_in_rdy;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 1'b1;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
`ifdef UART_PARITY_EN
        rx_par_bad_d = rx_par_bad_q;
`endif
        rx_push     = 1'b0;
        set_lost    = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
        set_overrun = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    if (rxd_sync_q != START_BIT) begin
                        set_lost   = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CPB_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PAR;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PAR: begin
                if (rx_cnt_q == CPB_LAST) begin
                    rx_cnt_d     = '0;
                    rx_par_bad_d = (rxd_sync_q != even_par(rx_shift_q));
                    rx_state_d   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_q == CPB_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rxd_sync_q != STOP_BIT) begin
                        set_frame = 1'b1;
                    end
`ifdef UART_PARITY_EN
                    else if (rx_par_bad_q) begin
                        set_parity = 1'b1;
                    end
`endif
                    else if (fifo_full && !rx_pop) begin
                        set_overrun = 1'b1;
                    end else begin
                        rx_push = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= 1'b0;
`endif
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= rx_par_bad_d;
`endif
        end
    end

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .wdat_i  (rx_shift_q),
        .pop_i   (rx_pop),
        .rdat_o  (io_in_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    logic [3:0] err_q, err_d, err_set;
    logic       any_q;

    // A new error in the clearing cycle survives the clear.
    always_comb begin
        err_set              = '0;
        err_set[ERR_PARITY]  = set_parity;
        err_set[ERR_FRAME]   = set_frame;
        err_set[ERR_OVERRUN] = set_overrun;
        err_set[ERR_LOST]    = set_lost;
        err_d                = (err_clr ? 4'b0000 : err_q) | err_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
            any_q <= 1'b0;
        end else begin
            err_q <= err_d;
            any_q <= |err_d;
        end
    end

    always_comb begin
        io_err          = '0;
        io_err[3:0]     = err_q;
        io_err[ERR_ANY] = any_q;
    end

endmodule
